// File: rtl/hazard_stall_unit.sv
// Stall/bubble controller for the 5-stage pipeline: compares ID operand use-times
// against shadow E/M produce-times and tracks the multiply/divide busy window.
module hazard_stall_unit #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       flush,
    input  logic [4:0] rs_addr,
    input  logic       rs_used,
    input  logic [1:0] rs_tuse,
    input  logic [4:0] rt_addr,
    input  logic       rt_used,
    input  logic [1:0] rt_tuse,
    input  logic [4:0] id_dst,
    input  logic [1:0] id_tnew,
    input  logic       id_md_start,
    input  logic       id_md_div,
    input  logic       id_md_use,
    output logic       stall,
    output logic       pc_en,
    output logic       d_en,
    output logic       e_clr,
    output logic       md_busy
);

    // md_cnt is only 4 bits wide
    if (DIV_CYCLES > 15 || MULT_CYCLES > 15 || DIV_CYCLES < 1 || MULT_CYCLES < 1) begin : g_bad_cycles
        $error("hazard_stall_unit: MULT_CYCLES/DIV_CYCLES must be in 1..15");
    end

    localparam logic [3:0] MULT_LOAD = 4'(MULT_CYCLES);
    localparam logic [3:0] DIV_LOAD  = 4'(DIV_CYCLES);

    logic [4:0] e_dst;
    logic [1:0] e_tnew;
    logic       e_md_start;
    logic       e_md_div;
    logic [4:0] m_dst;
    logic [1:0] m_tnew;
    logic [3:0] md_cnt;

    logic hz_rs;
    logic hz_rt;
    logic hz_md;

    function automatic logic operand_hazard(
        input logic [4:0] addr,
        input logic       used,
        input logic [1:0] tuse,
        input logic [4:0] edst,
        input logic [1:0] etnew,
        input logic [4:0] mdst,
        input logic [1:0] mtnew
    );
        // E and M are checked independently; W always has Tnew 0 and is forwarded
        return used && (addr != 5'd0) &&
               (((addr == edst) && (tuse < etnew)) ||
                ((addr == mdst) && (tuse < mtnew)));
    endfunction

    function automatic logic [1:0] sat_dec(input logic [1:0] x);
        return (x == 2'd0) ? 2'd0 : x - 2'd1;
    endfunction

    always_comb begin
        hz_rs   = operand_hazard(rs_addr, rs_used, rs_tuse, e_dst, e_tnew, m_dst, m_tnew);
        hz_rt   = operand_hazard(rt_addr, rt_used, rt_tuse, e_dst, e_tnew, m_dst, m_tnew);
        md_busy = (md_cnt != 4'd0);
        // e_md_start covers the cycle before the counter is loaded
        hz_md   = id_md_use && (md_busy || e_md_start);
        stall   = hz_rs || hz_rt || hz_md;
        pc_en   = !stall;
        d_en    = !stall;
        e_clr   = stall || flush;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            e_dst      <= 5'd0;
            e_tnew     <= 2'd0;
            e_md_start <= 1'b0;
            e_md_div   <= 1'b0;
            m_dst      <= 5'd0;
            m_tnew     <= 2'd0;
            md_cnt     <= 4'd0;
        end else begin
            if (!stall && !flush) begin
                e_dst      <= id_dst;
                e_tnew     <= id_tnew;
                e_md_start <= id_md_start;
                e_md_div   <= id_md_div;
            end else begin
                e_dst      <= 5'd0;
                e_tnew     <= 2'd0;
                e_md_start <= 1'b0;
                e_md_div   <= 1'b0;
            end

            if (!flush) begin
                m_dst  <= e_dst;
                m_tnew <= sat_dec(e_tnew);
            end else begin
                m_dst  <= 5'd0;
                m_tnew <= 2'd0;
            end

            // a flush does not abort an operation already counting
            if (e_md_start && !flush) begin
                md_cnt <= e_md_div ? DIV_LOAD : MULT_LOAD;
            end else if (md_cnt != 4'd0) begin
                md_cnt <= md_cnt - 4'd1;
            end
        end
    end

endmodule

// File: tb/tb_hazard_stall_unit.sv
// Directed bench for hazard_stall_unit; outputs are observed as the vector
// {stall, pc_en, d_en, e_clr, md_busy}.
module tb_hazard_stall_unit;

    logic       clk = 1'b0;
    logic       reset;
    logic       flush;
    logic [4:0] rs_addr;
    logic       rs_used;
    logic [1:0] rs_tuse;
    logic [4:0] rt_addr;
    logic       rt_used;
    logic [1:0] rt_tuse;
    logic [4:0] id_dst;
    logic [1:0] id_tnew;
    logic       id_md_start;
    logic       id_md_div;
    logic       id_md_use;
    logic       stall;
    logic       pc_en;
    logic       d_en;
    logic       e_clr;
    logic       md_busy;
    logic [4:0] outs;

    int tests_run    = 0;
    int tests_failed = 0;

    assign outs = {stall, pc_en, d_en, e_clr, md_busy};

    hazard_stall_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk(clk), .reset(reset), .flush(flush),
        .rs_addr(rs_addr), .rs_used(rs_used), .rs_tuse(rs_tuse),
        .rt_addr(rt_addr), .rt_used(rt_used), .rt_tuse(rt_tuse),
        .id_dst(id_dst), .id_tnew(id_tnew),
        .id_md_start(id_md_start), .id_md_div(id_md_div), .id_md_use(id_md_use),
        .stall(stall), .pc_en(pc_en), .d_en(d_en), .e_clr(e_clr), .md_busy(md_busy)
    );

    // clock / reset
    always #5 clk = ~clk;

    // driver tasks
    task automatic clear_id();
        rs_addr = 5'd0; rs_used = 1'b0; rs_tuse = 2'd0;
        rt_addr = 5'd0; rt_used = 1'b0; rt_tuse = 2'd0;
        id_dst = 5'd0; id_tnew = 2'd0;
        id_md_start = 1'b0; id_md_div = 1'b0; id_md_use = 1'b0;
    endtask

    task automatic set_rs(input logic [4:0] a, input logic u, input logic [1:0] t);
        rs_addr = a; rs_used = u; rs_tuse = t;
    endtask

    task automatic set_rt(input logic [4:0] a, input logic u, input logic [1:0] t);
        rt_addr = a; rt_used = u; rt_tuse = t;
    endtask

    task automatic set_dst(input logic [4:0] d, input logic [1:0] t);
        id_dst = d; id_tnew = t;
    endtask

    task automatic set_md(input logic s, input logic dv, input logic u);
        id_md_start = s; id_md_div = dv; id_md_use = u;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1; flush = 1'b0;
        clear_id();
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; flush = 1'b0;
        clear_id();
        repeat (2) @(negedge clk);
        reset = 1'b0;
        set_rs(5'd8, 1'b1, 2'd0);
        #1;
        tests_run++;
        if (outs !== 5'b01100) begin tests_failed++; $display("FAIL reset_outs: got=%b want=%b", outs, 5'b01100); end
    endtask

    task automatic test_load_use();
        do_reset();
        @(negedge clk); clear_id(); set_dst(5'd8, 2'd2); #1;
        tests_run++;
        if (outs !== 5'b01100) begin tests_failed++; $display("FAIL lw_issue: got=%b want=%b", outs, 5'b01100); end
        @(negedge clk); clear_id(); set_rs(5'd8, 1'b1, 2'd1); set_rt(5'd0, 1'b1, 2'd1); set_dst(5'd10, 2'd1); #1;
        tests_run++;
        if (outs !== 5'b10010) begin tests_failed++; $display("FAIL addu_stall: got=%b want=%b", outs, 5'b10010); end
        @(negedge clk); #1;
        tests_run++;
        if (outs !== 5'b01100) begin tests_failed++; $display("FAIL addu_release: got=%b want=%b", outs, 5'b01100); end
        // the addu ($10, Tnew 1) must now be in E
        @(negedge clk); clear_id(); set_rs(5'd10, 1'b1, 2'd0); #1;
        tests_run++;
        if (outs !== 5'b10010) begin tests_failed++; $display("FAIL addu_in_e: got=%b want=%b", outs, 5'b10010); end
    endtask

    task automatic test_branch_two_cycle();
        do_reset();
        @(negedge clk); clear_id(); set_dst(5'd9, 2'd2); #1;
        @(negedge clk); clear_id(); set_rs(5'd0, 1'b1, 2'd0); set_rt(5'd9, 1'b1, 2'd0); #1;
        tests_run++;
        if (outs !== 5'b10010) begin tests_failed++; $display("FAIL beq_stall_e: got=%b want=%b", outs, 5'b10010); end
        @(negedge clk); #1;
        tests_run++;
        if (outs !== 5'b10010) begin tests_failed++; $display("FAIL beq_stall_m: got=%b want=%b", outs, 5'b10010); end
        @(negedge clk); #1;
        tests_run++;
        if (outs !== 5'b01100) begin tests_failed++; $display("FAIL beq_release: got=%b want=%b", outs, 5'b01100); end
    endtask

    task automatic test_m_not_masked();
        do_reset();
        @(negedge clk); clear_id(); set_dst(5'd9, 2'd2); #1;
        @(negedge clk); clear_id(); set_dst(5'd9, 2'd0); #1;
        tests_run++;
        if (outs !== 5'b01100) begin tests_failed++; $display("FAIL m_mask_setup: got=%b want=%b", outs, 5'b01100); end
        // E holds $9 Tnew 0 (no hazard), M holds $9 Tnew 1 (hazard)
        @(negedge clk); clear_id(); set_rs(5'd9, 1'b1, 2'd0); #1;
        tests_run++;
        if (outs !== 5'b10010) begin tests_failed++; $display("FAIL m_not_masked: got=%b want=%b", outs, 5'b10010); end
    endtask

    task automatic test_zero_and_unused();
        do_reset();
        @(negedge clk); clear_id(); set_dst(5'd0, 2'd2); #1;
        @(negedge clk); clear_id(); set_rs(5'd0, 1'b1, 2'd0); set_dst(5'd8, 2'd2); #1;
        tests_run++;
        if (outs !== 5'b01100) begin tests_failed++; $display("FAIL reg_zero: got=%b want=%b", outs, 5'b01100); end
        @(negedge clk); clear_id(); set_rs(5'd8, 1'b0, 2'd0); #1;
        tests_run++;
        if (outs !== 5'b01100) begin tests_failed++; $display("FAIL rs_unused: got=%b want=%b", outs, 5'b01100); end
        set_rs(5'd8, 1'b1, 2'd2); #1;
        tests_run++;
        if (outs !== 5'b01100) begin tests_failed++; $display("FAIL tuse_eq_tnew: got=%b want=%b", outs, 5'b01100); end
        set_rs(5'd8, 1'b1, 2'd1); #1;
        tests_run++;
        if (outs !== 5'b10010) begin tests_failed++; $display("FAIL tuse_lt_tnew: got=%b want=%b", outs, 5'b10010); end
    endtask

    task automatic test_mult_window();
        do_reset();
        @(negedge clk); clear_id(); set_md(1'b1, 1'b0, 1'b1); #1;
        tests_run++;
        if (outs !== 5'b01100) begin tests_failed++; $display("FAIL mult_issue: got=%b want=%b", outs, 5'b01100); end
        @(negedge clk); clear_id(); set_md(1'b0, 1'b0, 1'b1); set_dst(5'd8, 2'd1); #1;
        tests_run++;
        if (outs !== 5'b10010) begin tests_failed++; $display("FAIL mflo_e_start: got=%b want=%b", outs, 5'b10010); end
        for (int i = 0; i < 5; i++) begin
            @(negedge clk); #1;
            tests_run++;
            if (outs !== 5'b10011) begin tests_failed++; $display("FAIL mflo_busy[%0d]: got=%b want=%b", i, outs, 5'b10011); end
        end
        @(negedge clk); #1;
        tests_run++;
        if (outs !== 5'b01100) begin tests_failed++; $display("FAIL mflo_issue: got=%b want=%b", outs, 5'b01100); end
    endtask

    task automatic test_div_flush();
        do_reset();
        @(negedge clk); clear_id(); set_md(1'b1, 1'b1, 1'b1); #1;
        @(negedge clk); clear_id(); #1;
        tests_run++;
        if (outs !== 5'b01100) begin tests_failed++; $display("FAIL div_e_no_use: got=%b want=%b", outs, 5'b01100); end
        @(negedge clk); #1;
        tests_run++;
        if (outs !== 5'b01101) begin tests_failed++; $display("FAIL div_busy10: got=%b want=%b", outs, 5'b01101); end
        @(negedge clk); clear_id(); set_dst(5'd9, 2'd2); #1;
        @(negedge clk); clear_id(); set_dst(5'd8, 2'd2); #1;
        // md_cnt = 7, E = $8 Tnew 2, M = $9 Tnew 1
        @(negedge clk); clear_id(); flush = 1'b1; set_rs(5'd8, 1'b1, 2'd0); #1;
        tests_run++;
        if (outs !== 5'b10011) begin tests_failed++; $display("FAIL flush_with_stall: got=%b want=%b", outs, 5'b10011); end
        @(negedge clk); flush = 1'b0; set_rt(5'd9, 1'b1, 2'd0); #1;
        tests_run++;
        if (outs !== 5'b01101) begin tests_failed++; $display("FAIL flush_killed_em: got=%b want=%b", outs, 5'b01101); end
        set_md(1'b0, 1'b0, 1'b1); #1;
        tests_run++;
        if (outs !== 5'b10011) begin tests_failed++; $display("FAIL mfhi_stall6: got=%b want=%b", outs, 5'b10011); end
        for (int i = 5; i >= 1; i--) begin
            @(negedge clk); #1;
            tests_run++;
            if (outs !== 5'b10011) begin tests_failed++; $display("FAIL mfhi_stall%0d: got=%b want=%b", i, outs, 5'b10011); end
        end
        @(negedge clk); #1;
        tests_run++;
        if (outs !== 5'b01100) begin tests_failed++; $display("FAIL mfhi_issue: got=%b want=%b", outs, 5'b01100); end
    endtask

    task automatic test_reset_mid_op();
        do_reset();
        @(negedge clk); clear_id(); set_md(1'b1, 1'b0, 1'b1); #1;
        @(negedge clk); clear_id(); set_md(1'b0, 1'b0, 1'b1); #1;
        @(negedge clk); #1;
        @(negedge clk); #1;
        tests_run++;
        if (outs !== 5'b10011) begin tests_failed++; $display("FAIL pre_reset_cnt4: got=%b want=%b", outs, 5'b10011); end
        reset = 1'b1;
        @(negedge clk); reset = 1'b0; #1;
        tests_run++;
        if (outs !== 5'b01100) begin tests_failed++; $display("FAIL reset_mid_op: got=%b want=%b", outs, 5'b01100); end
    endtask

    initial begin
        test_reset();
        test_load_use();
        test_branch_two_cycle();
        test_m_not_masked();
        test_zero_and_unused();
        test_mult_window();
        test_div_flush();
        test_reset_mid_op();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
